// File: rtl/array_multiplier.sv
// Unsigned DATAWIDTH x DATAWIDTH AND-array / ripple-carry multiplier with a valid-tagged output pipeline.
// Optional feature: define ARRAY_MULT_ZERO_INVALID_EN to force Z_final to 0 whenever o_valid is low.
module array_multiplier #(
    parameter int DATAWIDTH           = 4,
    parameter int NUM_PIPELINE_STAGES = 1,
    parameter int INSTANCE_ID         = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_valid,
    input  logic [DATAWIDTH-1:0]     A,
    input  logic [DATAWIDTH-1:0]     B,
    output logic [2*DATAWIDTH-1:0]   Z_final,
    output logic                     o_valid
);

    if (DATAWIDTH < 2 || NUM_PIPELINE_STAGES < 0 || INSTANCE_ID < 0) begin : g_param_check
        $error("array_multiplier: illegal parameter value");
    end

    // Row j of partial products is added into the upper DATAWIDTH bits of the running sum;
    // the bit that drops out of the bottom of each row is a finished product bit.
    // NOTE: blocking '=' is correct inside this combinational function; state uses '<=' only.
    function automatic logic [2*DATAWIDTH-1:0] array_product(
        input logic [DATAWIDTH-1:0] a,
        input logic [DATAWIDTH-1:0] b
    );
        logic [DATAWIDTH-1:0]   pp;
        logic [DATAWIDTH-1:0]   sum;
        logic [DATAWIDTH:0]     acc;
        logic [2*DATAWIDTH-1:0] prod;
        logic                   c;
        prod    = '0;
        acc     = {1'b0, a & {DATAWIDTH{b[0]}}};
        prod[0] = acc[0];
        for (int j = 1; j < DATAWIDTH; j++) begin
            pp  = a & {DATAWIDTH{b[j]}};
            sum = '0;
            c   = 1'b0;
            for (int i = 0; i < DATAWIDTH; i++) begin
                sum[i] = acc[i+1] ^ pp[i] ^ c;
                c      = (acc[i+1] & pp[i]) | (acc[i+1] & c) | (pp[i] & c);
            end
            acc     = {c, sum};
            prod[j] = acc[0];
        end
        prod[2*DATAWIDTH-1:DATAWIDTH] = acc[DATAWIDTH:1];
        return prod;
    endfunction

    logic [2*DATAWIDTH-1:0] z_d;
    logic                   v_d;
    logic [2*DATAWIDTH-1:0] z_last;
    logic                   v_last;

    assign z_d = array_product(A, B);
    assign v_d = i_valid;

    if (NUM_PIPELINE_STAGES == 0) begin : g_comb
        assign z_last = z_d;
        assign v_last = v_d;
    end else begin : g_pipe
        logic [2*DATAWIDTH-1:0] z_q [NUM_PIPELINE_STAGES];
        logic                   v_q [NUM_PIPELINE_STAGES];

        // NOTE: the data stages are reset as well as the valid bits, so Z_final reads 0
        // from the first reset edge instead of showing stale products.
        always_ff @(posedge clk) begin
            if (!rst) begin
                for (int s = 0; s < NUM_PIPELINE_STAGES; s++) begin
                    z_q[s] <= '0;
                    v_q[s] <= 1'b0;
                end
            end else begin
                z_q[0] <= z_d;
                v_q[0] <= v_d;
                for (int s = 1; s < NUM_PIPELINE_STAGES; s++) begin
                    z_q[s] <= z_q[s-1];
                    v_q[s] <= v_q[s-1];
                end
            end
        end

        assign z_last = z_q[NUM_PIPELINE_STAGES-1];
        assign v_last = v_q[NUM_PIPELINE_STAGES-1];
    end

`ifdef ARRAY_MULT_ZERO_INVALID_EN
    assign Z_final = v_last ? z_last : '0;
`else
    assign Z_final = z_last;
`endif
    assign o_valid = v_last;

endmodule

// File: tb/tb_array_multiplier.sv
// Directed self-checking bench for array_multiplier: 4x4 with one stage, 8x8 with zero and three stages.
module tb_array_multiplier;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // 4x4, one stage
    logic       v4;
    logic [3:0] a4, b4;
    logic [7:0] z4;
    logic       ov4;
    // 8x8, combinational
    logic        v8;
    logic [7:0]  a8, b8;
    logic [15:0] z8;
    logic        ov8;
    // 8x8, three stages
    logic        v3;
    logic [7:0]  a3, b3;
    logic [15:0] z3;
    logic        ov3;

    array_multiplier #(.DATAWIDTH(4), .NUM_PIPELINE_STAGES(1), .INSTANCE_ID(0)) dut1 (
        .clk(clk), .rst(rst), .i_valid(v4), .A(a4), .B(b4), .Z_final(z4), .o_valid(ov4)
    );
    array_multiplier #(.DATAWIDTH(8), .NUM_PIPELINE_STAGES(0), .INSTANCE_ID(1)) dut0 (
        .clk(clk), .rst(rst), .i_valid(v8), .A(a8), .B(b8), .Z_final(z8), .o_valid(ov8)
    );
    array_multiplier #(.DATAWIDTH(8), .NUM_PIPELINE_STAGES(3), .INSTANCE_ID(2)) dut3 (
        .clk(clk), .rst(rst), .i_valid(v3), .A(a3), .B(b3), .Z_final(z3), .o_valid(ov3)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Expected Z_final in a slot whose valid bit is v, given the product p sampled there.
    function automatic logic [31:0] gated(input logic [31:0] p, input logic v);
`ifdef ARRAY_MULT_ZERO_INVALID_EN
        return v ? p : 32'd0;
`else
        return p;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       v;
        logic [7:0] z;
        logic       ov;
    } vec_t;

    vec_t tbl [10];

    initial begin
        // Streaming table: each row is applied for one cycle, its result checked one cycle later.
        tbl[0] = '{4'd15, 4'd15, 1'b1, 8'd225, 1'b1};
        tbl[1] = '{4'd15, 4'd9,  1'b1, 8'd135, 1'b1};
        tbl[2] = '{4'd10, 4'd15, 1'b1, 8'd150, 1'b1};
        tbl[3] = '{4'd0,  4'd13, 1'b1, 8'd0,   1'b1};
        tbl[4] = '{4'd11, 4'd0,  1'b1, 8'd0,   1'b1};
        tbl[5] = '{4'd3,  4'd5,  1'b1, 8'd15,  1'b1};
        tbl[6] = '{4'd3,  4'd5,  1'b0, 8'(gated(32'd15, 1'b0)), 1'b0};
        tbl[7] = '{4'd3,  4'd5,  1'b1, 8'd15,  1'b1};
        tbl[8] = '{4'd1,  4'd1,  1'b1, 8'd1,   1'b1};
        tbl[9] = '{4'd7,  4'd6,  1'b0, 8'(gated(32'd42, 1'b0)), 1'b0};

        // Reset with non-zero valid inputs present: everything must still clear.
        rst = 1'b0;
        a4 = 4'd15; b4 = 4'd15; v4 = 1'b1;
        a8 = 8'd0;  b8 = 8'd0;  v8 = 1'b0;
        a3 = 8'd255; b3 = 8'd255; v3 = 1'b1;
        repeat (2) begin
            tick();
            check("reset z4", 32'(z4), 32'd0);
            check("reset ov4", 32'(ov4), 32'd0);
            check("reset z3", 32'(z3), 32'd0);
            check("reset ov3", 32'(ov3), 32'd0);
        end

        rst = 1'b1;
        a4 = 4'd0; b4 = 4'd0; v4 = 1'b0;
        a3 = 8'd0; b3 = 8'd0; v3 = 1'b0;
        repeat (2) begin
            tick();
            check("idle z4", 32'(z4), 32'd0);
            check("idle ov4", 32'(ov4), 32'd0);
        end

        for (int i = 0; i < 10; i++) begin
            a4 = tbl[i].a; b4 = tbl[i].b; v4 = tbl[i].v;
            tick();
            check($sformatf("tbl[%0d] z4", i), 32'(z4), 32'(tbl[i].z));
            check($sformatf("tbl[%0d] ov4", i), 32'(ov4), 32'(tbl[i].ov));
        end

        // Exhaustive 4x4 sweep, one pair per cycle.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                a4 = 4'(a); b4 = 4'(b); v4 = 1'b1;
                tick();
                check($sformatf("sweep %0dx%0d", a, b), 32'(z4), 32'(a * b));
            end
        end

        // Mid-stream reset drops the in-flight result.
        a4 = 4'd9; b4 = 4'd9; v4 = 1'b1;
        tick();
        check("pre-reset z4", 32'(z4), 32'd81);
        check("pre-reset ov4", 32'(ov4), 32'd1);
        rst = 1'b0;
        a4 = 4'd13; b4 = 4'd14; v4 = 1'b1;
        tick();
        check("midreset z4", 32'(z4), 32'd0);
        check("midreset ov4", 32'(ov4), 32'd0);
        rst = 1'b1;
        a4 = 4'd5; b4 = 4'd5; v4 = 1'b0;
        tick();
        check("post-reset bubble z4", 32'(z4), gated(32'd25, 1'b0));
        check("post-reset bubble ov4", 32'(ov4), 32'd0);
        a4 = 4'd12; b4 = 4'd12; v4 = 1'b1;
        tick();
        check("post-reset first z4", 32'(z4), 32'd144);
        check("post-reset first ov4", 32'(ov4), 32'd1);
        a4 = 4'd0; b4 = 4'd0; v4 = 1'b0;
        tick();
        check("post-reset drain ov4", 32'(ov4), 32'd0);

        // 8x8 combinational: result visible without a clock edge.
        a8 = 8'd255; b8 = 8'd255; v8 = 1'b1;
        #1;
        check("comb z8", 32'(z8), 32'd65025);
        check("comb ov8", 32'(ov8), 32'd1);
        v8 = 1'b0;
        #1;
        check("comb invalid z8", 32'(z8), gated(32'd65025, 1'b0));
        check("comb invalid ov8", 32'(ov8), 32'd0);
        a8 = 8'd200; b8 = 8'd3; v8 = 1'b1;
        #1;
        check("comb 200x3 z8", 32'(z8), 32'd600);

        // 8x8 three-stage: single valid pulse emerges on the third edge only.
        a3 = 8'd255; b3 = 8'd255; v3 = 1'b1;
        tick();
        check("pipe3 e1 ov3", 32'(ov3), 32'd0);
        check("pipe3 e1 z3", 32'(z3), 32'd0);
        a3 = 8'd0; b3 = 8'd0; v3 = 1'b0;
        tick();
        check("pipe3 e2 ov3", 32'(ov3), 32'd0);
        check("pipe3 e2 z3", 32'(z3), 32'd0);
        tick();
        check("pipe3 e3 ov3", 32'(ov3), 32'd1);
        check("pipe3 e3 z3", 32'(z3), 32'd65025);
        tick();
        check("pipe3 e4 ov3", 32'(ov3), 32'd0);
        check("pipe3 e4 z3", 32'(z3), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
